// File: rtl/ppm_pulse_tx.sv
// PPM pulse transmitter: preamble, MSB-first PPM symbols, silent guard slot.
// Define PPM_PULSE_TX_PARITY_EN to append an even-parity symbol window.
module ppm_pulse_tx #(
    parameter int PULSE_CT = 30,
    parameter int N_MOD    = 2,
    parameter int L        = 40,
    parameter int N_PKT    = 8,
    parameter int PRE_CT   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_PKT-1:0] data,
    input  logic             start,
    output logic             avail,
    output logic             pulse,
    output logic             done
);

    localparam int NSLOT = 1 << N_MOD;
    localparam int NSYM  = N_PKT / N_MOD;
`ifdef PPM_PULSE_TX_PARITY_EN
    localparam int NWIN  = NSYM + 1;
`else
    localparam int NWIN  = NSYM;
`endif
    localparam int CW    = (L > 1) ? $clog2(L) : 1;
    localparam int SMAX  = (PRE_CT > NSLOT) ? PRE_CT : NSLOT;
    localparam int SW    = $clog2(SMAX) + 1;
    localparam int YW    = $clog2(NWIN) + 1;

    localparam logic [CW-1:0] CYC_LAST  = CW'(L - 1);
    localparam logic [CW-1:0] PULSE_C   = CW'(PULSE_CT);
    localparam logic [SW-1:0] PRE_LAST  = SW'(PRE_CT - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NSLOT - 1);
    localparam logic [YW-1:0] WIN_LAST  = YW'(NWIN - 1);

    if (N_PKT % N_MOD != 0) begin : g_pkt_chk
        $error("N_PKT must be a multiple of N_MOD");
    end
    if (PULSE_CT >= L) begin : g_pulse_chk
        $error("PULSE_CT must be less than L");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_SYM,
        S_GUARD
    } state_t;

    state_t           state, nxt_state;
    logic [CW-1:0]    cyc, nxt_cyc;
    logic [SW-1:0]    slot, nxt_slot;
    logic [YW-1:0]    sym, nxt_sym;
    logic [N_PKT-1:0] shreg, nxt_shreg;
    logic [N_MOD-1:0] nxt_val;
    logic             pulse_d, done_d;
    logic             cyc_last;
`ifdef PPM_PULSE_TX_PARITY_EN
    localparam logic [YW-1:0] PAR_WIN = YW'(NSYM);
    logic             par, nxt_par;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cyc   <= '0;
            slot  <= '0;
            sym   <= '0;
            shreg <= '0;
            pulse <= 1'b0;
            done  <= 1'b0;
`ifdef PPM_PULSE_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= nxt_state;
            cyc   <= nxt_cyc;
            slot  <= nxt_slot;
            sym   <= nxt_sym;
            shreg <= nxt_shreg;
            pulse <= pulse_d;
            done  <= done_d;
`ifdef PPM_PULSE_TX_PARITY_EN
            par   <= nxt_par;
`endif
        end
    end

    assign cyc_last = (cyc == CYC_LAST);

    always_comb begin
        nxt_state = state;
        nxt_cyc   = cyc_last ? '0 : cyc + 1'b1;
        nxt_slot  = slot;
        nxt_sym   = sym;
        nxt_shreg = shreg;
`ifdef PPM_PULSE_TX_PARITY_EN
        nxt_par   = par;
`endif
        unique case (state)
            S_IDLE: begin
                nxt_cyc = '0;
                if (start) begin
                    nxt_state = S_PRE;
                    nxt_slot  = '0;
                    nxt_sym   = '0;
                    nxt_shreg = data;
`ifdef PPM_PULSE_TX_PARITY_EN
                    nxt_par   = ^data;
`endif
                end
            end
            S_PRE: begin
                if (cyc_last) begin
                    if (slot == PRE_LAST) begin
                        nxt_state = S_SYM;
                        nxt_slot  = '0;
                    end else begin
                        nxt_slot = slot + 1'b1;
                    end
                end
            end
            S_SYM: begin
                if (cyc_last) begin
                    if (slot == SLOT_LAST) begin
                        nxt_slot  = '0;
                        nxt_shreg = shreg << N_MOD;
                        if (sym == WIN_LAST) begin
                            nxt_state = S_GUARD;
                        end else begin
                            nxt_sym = sym + 1'b1;
                        end
                    end else begin
                        nxt_slot = slot + 1'b1;
                    end
                end
            end
            S_GUARD: begin
                if (cyc_last) begin
                    nxt_state = S_IDLE;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // The output registers are loaded from the upcoming cycle's position,
    // so the pin tracks the frame with no extra latency.
    always_comb begin
        nxt_val = nxt_shreg[N_PKT-1 -: N_MOD];
`ifdef PPM_PULSE_TX_PARITY_EN
        if (nxt_sym == PAR_WIN) begin
            nxt_val = N_MOD'(nxt_par);
        end
`endif
        pulse_d = 1'b0;
        if (nxt_cyc < PULSE_C) begin
            if (nxt_state == S_PRE) begin
                pulse_d = 1'b1;
            end else if (nxt_state == S_SYM) begin
                pulse_d = (nxt_slot == SW'(nxt_val));
            end
        end
        done_d = (nxt_state == S_GUARD) && (nxt_cyc == CYC_LAST);
    end

    assign avail = (state == S_IDLE);

endmodule

// File: tb/tb_ppm_pulse_tx.sv
// Self-checking bench for ppm_pulse_tx: vector table, corner sequences,
// and random packets against a slot-arithmetic reference model.
module tb_ppm_pulse_tx;

    localparam int PULSE_CT = 30;
    localparam int N_MOD    = 2;
    localparam int L        = 40;
    localparam int N_PKT    = 8;
    localparam int PRE_CT   = 4;
    localparam int NSLOT    = 1 << N_MOD;
    localparam int NSYM     = N_PKT / N_MOD;
`ifdef PPM_PULSE_TX_PARITY_EN
    localparam int NWIN     = NSYM + 1;
`else
    localparam int NWIN     = NSYM;
`endif
    localparam int F = (PRE_CT + NWIN * NSLOT + 1) * L;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_PKT-1:0] data;
    logic             start;
    logic             avail;
    logic             pulse;
    logic             done;

    int passed = 0;
    int total  = 0;
    logic wave [0:F-1];

    always #5 clk = ~clk;

    ppm_pulse_tx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .start (start),
        .avail (avail),
        .pulse (pulse),
        .done  (done)
    );

    typedef struct {
        logic [N_PKT-1:0] data;
        int               pos [NSYM];
    } vec_t;

    vec_t tbl [4];

    // Expected pin level at a frame offset, from slot/window arithmetic.
    function automatic logic exp_pulse(logic [N_PKT-1:0] d, int off);
        int slot, c, w, s, v;
        slot = off / L;
        c    = off % L;
        if (c >= PULSE_CT) return 1'b0;
        if (slot < PRE_CT) return 1'b1;
        w = (slot - PRE_CT) / NSLOT;
        s = (slot - PRE_CT) % NSLOT;
        if (w < NSYM) v = (int'(d) >> (N_PKT - N_MOD * (w + 1))) % NSLOT;
        else if (w < NWIN) v = int'(^d);
        else return 1'b0;
        return (s == v);
    endfunction

    task automatic chk(string nm, int off, logic act, logic exp_v);
        total++;
        if (act === exp_v) passed++;
        else $display("FAIL %s @off %0d: got %b expected %b",
                      nm, off, act, exp_v);
    endtask

    task automatic chk_int(string nm, int act, int exp_v);
        total++;
        if (act == exp_v) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endtask

    task automatic run_frame(input logic [N_PKT-1:0] d,
                             input int ign_off, input bit hold);
        chk("avail_pre", -1, avail, 1'b1);
        data  = d;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int off = 0; off < F; off++) begin
            wave[off] = pulse;
            chk("pulse", off, pulse, exp_pulse(d, off));
            chk("done", off, done, off == F - 1);
            chk("avail", off, avail, 1'b0);
            if (off == ign_off) begin
                start = 1'b1;
                data  = 8'hFF;
            end else if (ign_off >= 0 && off == ign_off + 1) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("avail_end", F, avail, 1'b1);
        chk("pulse_end", F, pulse, 1'b0);
        chk("done_end", F, done, 1'b0);
    endtask

    task automatic quiet(input int n, input string nm);
        int hi = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (pulse !== 1'b0 || done !== 1'b0 || avail !== 1'b1) hi++;
        end
        chk_int(nm, hi, 0);
    endtask

    initial begin
        tbl[0].data = 8'hB4; tbl[0].pos = '{240, 440, 520, 640};
        tbl[1].data = 8'h00; tbl[1].pos = '{160, 320, 480, 640};
        tbl[2].data = 8'hFF; tbl[2].pos = '{280, 440, 600, 760};
        tbl[3].data = 8'h1B; tbl[3].pos = '{160, 360, 560, 760};

        rst_n = 1'b0;
        start = 1'b0;
        data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_avail", 0, avail, 1'b1);
        chk("rst_pulse", 0, pulse, 1'b0);
        chk("rst_done", 0, done, 1'b0);
        quiet(2000, "idle_quiet");

        for (int i = 0; i < 4; i++) begin
            run_frame(tbl[i].data, -1, 1'b0);
            for (int w = 0; w < NSYM; w++) begin
                int base, first;
                base  = (PRE_CT + w * NSLOT) * L;
                first = -1;
                for (int k = base + NSLOT * L - 1; k >= base; k--)
                    if (wave[k] === 1'b1) first = k;
                chk_int($sformatf("tbl%0d_win%0d", i, w),
                        first, tbl[i].pos[w]);
            end
        end

        run_frame(8'hB4, 300, 1'b0);
        quiet(100, "ignored_start_quiet");

        run_frame(8'h00, -1, 1'b1);
        run_frame(8'h00, -1, 1'b1);
        start = 1'b0;
        quiet(50, "b2b_stop_quiet");

        data  = 8'hB4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (250) @(posedge clk);
        #1;
        chk("mid_pulse", 250, pulse, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_pulse", 251, pulse, 1'b0);
        chk("mid_rst_done", 251, done, 1'b0);
        chk("mid_rst_avail", 251, avail, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet(1000, "post_rst_quiet");

`ifdef PPM_PULSE_TX_PARITY_EN
        run_frame(8'h01, -1, 1'b0);
        chk("par1_pulse", 840, wave[840], 1'b1);
        run_frame(8'hB4, -1, 1'b0);
        chk("par0_pulse", 800, wave[800], 1'b1);
`endif

        for (int r = 0; r < 6; r++) begin
            run_frame(N_PKT'($urandom), -1, 1'b0);
            repeat ($urandom_range(0, 5)) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
